// File: rtl/drum_step_scheduler.sv
// drum_step_scheduler: sequences drum-mesh solver time steps across NCOLS
// column engines. It runs the init sweep, launches one compute step per audio
// tick, applies rho_eff updates only at step boundaries, captures the centre
// node sample and hands it to the audio path over valid/ready.
//
// Ports:
//   clk_50, reset          clock, asynchronous active-low reset
//   sample_tick            one-cycle request for a time step
//   init_req               one-cycle request for a new init sweep (strike)
//   rho_in, rho_wr         new rho_eff value and its shadow-register load
//   col_done[NCOLS]        per-column done pulses (init or step)
//   center_val             centre node u_next, held one cycle past the last done
//   col_init, col_start    one-cycle pulses to all columns
//   rho_eff                coefficient to all columns, stable within a step
//   audio_data/valid/ready captured sample handshake
//   busy                   low only when idle
//   step_count             completed steps since last init sweep
//   overrun, timeout_err   sticky error flags, cleared only by reset
module drum_step_scheduler #(
  parameter int unsigned NCOLS       = 1,
  parameter logic [17:0] RHO_DEFAULT = 18'h02000,
  parameter int unsigned TIMEOUT     = 1023
) (
  input  logic              clk_50,
  input  logic              reset,
  input  logic              sample_tick,
  input  logic              init_req,
  input  logic [17:0]       rho_in,
  input  logic              rho_wr,
  input  logic [NCOLS-1:0]  col_done,
  input  logic [17:0]       center_val,
  output logic              col_init,
  output logic              col_start,
  output logic [17:0]       rho_eff,
  output logic [17:0]       audio_data,
  output logic              audio_valid,
  input  logic              audio_ready,
  output logic              busy,
  output logic [31:0]       step_count,
  output logic              overrun,
  output logic              timeout_err
);

  localparam int unsigned TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [NCOLS-1:0] ALL_DONE = '1;

  typedef enum logic [2:0] {
    S_INIT,
    S_IWAIT,
    S_IDLE,
    S_START,
    S_WAIT
  } state_t;

  state_t           state;
  logic [NCOLS-1:0] done_mask;
  logic [NCOLS-1:0] mask_now;
  logic [TW-1:0]    timer;
  logic [17:0]      shadow;
  logic             init_pend;
  logic             accept;

  // Mask including pulses arriving this cycle; audio sink acceptance.
  assign mask_now = done_mask | col_done;
  assign accept   = audio_valid & audio_ready;

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      state       <= S_INIT;
      done_mask   <= '0;
      timer       <= '0;
      shadow      <= RHO_DEFAULT;
      init_pend   <= 1'b0;
      col_init    <= 1'b0;
      col_start   <= 1'b0;
      rho_eff     <= RHO_DEFAULT;
      audio_data  <= '0;
      audio_valid <= 1'b0;
      busy        <= 1'b1;
      step_count  <= '0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      col_init  <= 1'b0;
      col_start <= 1'b0;

      if (rho_wr) begin
        shadow <= rho_in;
      end

      // A capture later in this block overrides the acceptance clear.
      if (accept) begin
        audio_valid <= 1'b0;
      end

      // Outside idle, ticks are lost and init requests wait for idle.
      if (state != S_IDLE) begin
        if (sample_tick) overrun   <= 1'b1;
        if (init_req)    init_pend <= 1'b1;
      end

      case (state)
        S_INIT: begin
          col_init  <= 1'b1;
          done_mask <= '0;
          busy      <= 1'b1;
          state     <= S_IWAIT;
        end

        S_IWAIT: begin
          if (mask_now == ALL_DONE) begin
            done_mask  <= '0;
            step_count <= '0;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end else begin
            done_mask <= mask_now;
          end
        end

        S_IDLE: begin
          // Init wins over a simultaneous tick, which is then lost.
          if (init_req || init_pend) begin
            init_pend <= 1'b0;
            if (sample_tick) overrun <= 1'b1;
            busy  <= 1'b1;
            state <= S_INIT;
          end else if (sample_tick) begin
            busy  <= 1'b1;
            state <= S_START;
          end
        end

        S_START: begin
          col_start <= 1'b1;
          rho_eff   <= shadow;
          done_mask <= '0;
          timer     <= '0;
          state     <= S_WAIT;
        end

        S_WAIT: begin
          // Capture one cycle after the mask fills; center_val is still valid.
          if (done_mask == ALL_DONE) begin
            audio_data  <= center_val;
            audio_valid <= 1'b1;
            if (audio_valid && !audio_ready) overrun <= 1'b1;
            step_count  <= step_count + 32'd1;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end else if (timer == TW'(TIMEOUT)) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end else begin
            done_mask <= mask_now;
            timer     <= timer + TW'(1);
          end
        end

        default: begin
          busy  <= 1'b1;
          state <= S_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_drum_step_scheduler.sv
// Bench for drum_step_scheduler: directed stimulus, literal expectations and
// a phase-level model compared against the DUT on every falling clock edge.
module tb_drum_step_scheduler;

  localparam int unsigned NC  = 2;
  localparam int unsigned TO  = 15;
  localparam logic [17:0] RHO = 18'h02000;
  localparam logic [NC-1:0] ALL = 2'b11;

  logic          clk_50, reset;
  logic          sample_tick, init_req, rho_wr, audio_ready;
  logic [17:0]   rho_in, center_val;
  logic [NC-1:0] col_done;
  logic          col_init, col_start, audio_valid, busy, overrun, timeout_err;
  logic [17:0]   rho_eff, audio_data;
  logic [31:0]   step_count;

  drum_step_scheduler #(.NCOLS(NC), .RHO_DEFAULT(RHO), .TIMEOUT(TO)) dut (
    .clk_50(clk_50), .reset(reset), .sample_tick(sample_tick),
    .init_req(init_req), .rho_in(rho_in), .rho_wr(rho_wr),
    .col_done(col_done), .center_val(center_val), .col_init(col_init),
    .col_start(col_start), .rho_eff(rho_eff), .audio_data(audio_data),
    .audio_valid(audio_valid), .audio_ready(audio_ready), .busy(busy),
    .step_count(step_count), .overrun(overrun), .timeout_err(timeout_err)
  );

  initial clk_50 = 1'b0;
  always #10 clk_50 = ~clk_50;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  // Phase-level model: what the scheduler is doing, in terms of sweeps and steps.
  typedef enum int {PH_LAUNCH_SWEEP, PH_SWEEP, PH_READY, PH_LAUNCH_STEP, PH_STEP} phase_t;
  phase_t        m_ph;
  logic [NC-1:0] m_seen;
  int            m_age;
  logic          m_pend;
  logic [17:0]   m_shadow;
  logic          e_col_init, e_col_start, e_av, e_ovr, e_to;
  logic [17:0]   e_rho, e_ad;
  logic [31:0]   e_sc;

  task automatic model_reset();
    m_ph = PH_LAUNCH_SWEEP; m_seen = '0; m_age = 0; m_pend = 1'b0;
    m_shadow = RHO; e_rho = RHO;
    e_col_init = 1'b0; e_col_start = 1'b0; e_av = 1'b0; e_ovr = 1'b0;
    e_to = 1'b0; e_ad = '0; e_sc = '0;
  endtask

  // Advance model by one clock using the inputs the next rising edge samples.
  task automatic model_advance();
    logic [17:0] old_shadow;
    logic        captured, accepted;
    old_shadow = m_shadow;
    captured   = 1'b0;
    accepted   = e_av && audio_ready;
    if (rho_wr) m_shadow = rho_in;
    e_col_init  = 1'b0;
    e_col_start = 1'b0;
    if (m_ph != PH_READY) begin
      if (sample_tick) e_ovr = 1'b1;
      if (init_req) m_pend = 1'b1;
    end
    case (m_ph)
      PH_LAUNCH_SWEEP: begin e_col_init = 1'b1; m_seen = '0; m_ph = PH_SWEEP; end
      PH_SWEEP: begin
        m_seen = m_seen | col_done;
        if (m_seen == ALL) begin e_sc = 0; m_ph = PH_READY; end
      end
      PH_READY: begin
        if (init_req || m_pend) begin
          m_pend = 1'b0;
          if (sample_tick) e_ovr = 1'b1;
          m_ph = PH_LAUNCH_SWEEP;
        end else if (sample_tick) m_ph = PH_LAUNCH_STEP;
      end
      PH_LAUNCH_STEP: begin
        e_col_start = 1'b1; e_rho = old_shadow; m_seen = '0; m_age = 0; m_ph = PH_STEP;
      end
      default: begin
        if (m_seen == ALL) captured = 1'b1;
        else if (m_age == int'(TO)) begin e_to = 1'b1; m_ph = PH_READY; end
        else begin m_seen = m_seen | col_done; m_age++; end
      end
    endcase
    if (captured) begin
      if (e_av && !accepted) e_ovr = 1'b1;
      e_ad = center_val; e_av = 1'b1; e_sc = e_sc + 1; m_ph = PH_READY;
    end else if (accepted) e_av = 1'b0;
  endtask

  // Per-cycle comparison against the model.
  initial begin
    model_reset();
    forever begin
      @(negedge clk_50);
      if (!reset) model_reset();
      chk("cyc_col_init", 32'(col_init), 32'(e_col_init));
      chk("cyc_col_start", 32'(col_start), 32'(e_col_start));
      chk("cyc_rho_eff", 32'(rho_eff), 32'(e_rho));
      chk("cyc_audio_data", 32'(audio_data), 32'(e_ad));
      chk("cyc_audio_valid", 32'(audio_valid), 32'(e_av));
      chk("cyc_busy", 32'(busy), 32'(m_ph != PH_READY));
      chk("cyc_step_count", step_count, e_sc);
      chk("cyc_overrun", 32'(overrun), 32'(e_ovr));
      chk("cyc_timeout_err", 32'(timeout_err), 32'(e_to));
      if (reset) model_advance();
    end
  end

  task automatic cyc();
    @(posedge clk_50);
    #1;
  endtask

  // Leaves the DUT having just sampled the tick (entering the start state).
  task automatic pulse_tick();
    sample_tick = 1'b1; cyc(); sample_tick = 1'b0;
  endtask

  // All columns finish; capture happens on the second edge.
  task automatic step_done(input logic [17:0] c);
    col_done = ALL; center_val = c; cyc(); col_done = '0; cyc();
  endtask

  task automatic sweep();
    int n;
    n = 0;
    while (col_init !== 1'b1 && n < 10) begin cyc(); n++; end
    chk("sweep_col_init_seen", 32'(col_init), 32'd1);
    col_done = ALL; cyc(); col_done = '0;
  endtask

  initial begin
    reset = 1'b1; sample_tick = 1'b0; init_req = 1'b0; rho_wr = 1'b0;
    rho_in = '0; col_done = '0; center_val = '0; audio_ready = 1'b0;
    #5 reset = 1'b0;
    repeat (3) @(posedge clk_50);
    #1;
    chk("rst_col_init", 32'(col_init), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_step_count", step_count, 32'd0);
    chk("rst_rho_eff", 32'(rho_eff), 32'h02000);
    chk("rst_audio_valid", 32'(audio_valid), 32'd0);
    chk("rst_audio_data", 32'(audio_data), 32'd0);
    reset = 1'b1;

    // Init sweep with staggered column completions.
    cyc(); chk("init_pulse", 32'(col_init), 32'd1);
    cyc(); chk("init_single", 32'(col_init), 32'd0);
    repeat (3) cyc();
    col_done = 2'b01; cyc(); col_done = '0;
    repeat (3) cyc();
    col_done = 2'b10;
    chk("iwait_busy", 32'(busy), 32'd1);
    cyc(); col_done = '0;
    chk("iwait_idle", 32'(busy), 32'd0);
    chk("iwait_step_count", step_count, 32'd0);
    chk("iwait_rho", 32'(rho_eff), 32'h02000);

    // First step.
    pulse_tick();
    chk("start_not_yet", 32'(col_start), 32'd0);
    cyc(); chk("start_pulse", 32'(col_start), 32'd1);
    col_done = ALL; center_val = 18'h01B4C; cyc(); col_done = '0;
    chk("start_single", 32'(col_start), 32'd0);
    chk("cap_not_yet", 32'(audio_valid), 32'd0);
    cyc();
    chk("cap_data", 32'(audio_data), 32'h01B4C);
    chk("cap_valid", 32'(audio_valid), 32'd1);
    chk("cap_count", step_count, 32'd1);
    chk("cap_idle", 32'(busy), 32'd0);
    audio_ready = 1'b1; cyc(); audio_ready = 1'b0;
    chk("consume_valid", 32'(audio_valid), 32'd0);

    // rho_wr mid-step only takes effect at the next step start.
    pulse_tick(); cyc();
    rho_wr = 1'b1; rho_in = 18'h04000; cyc(); rho_wr = 1'b0;
    chk("rho_hold_mid", 32'(rho_eff), 32'h02000);
    step_done(18'h00100);
    chk("rho_hold_end", 32'(rho_eff), 32'h02000);
    chk("step2_count", step_count, 32'd2);
    pulse_tick(); cyc();
    chk("rho_new", 32'(rho_eff), 32'h04000);
    step_done(18'h3FF00);
    chk("ovw_data", 32'(audio_data), 32'h3FF00);
    chk("ovw_overrun", 32'(overrun), 32'd1);
    chk("step3_count", step_count, 32'd3);

    // Reset in the middle of a step.
    pulse_tick(); cyc();
    reset = 1'b0; #1;
    chk("mid_rst_valid", 32'(audio_valid), 32'd0);
    chk("mid_rst_overrun", 32'(overrun), 32'd0);
    chk("mid_rst_rho", 32'(rho_eff), 32'h02000);
    chk("mid_rst_count", step_count, 32'd0);
    cyc(); reset = 1'b1;
    sweep();
    chk("post_rst_idle", 32'(busy), 32'd0);

    // Capture on the same edge as acceptance: no overrun.
    pulse_tick(); cyc(); step_done(18'h00111);
    pulse_tick(); cyc();
    col_done = ALL; center_val = 18'h00222; cyc(); col_done = '0;
    audio_ready = 1'b1; cyc(); audio_ready = 1'b0;
    chk("same_edge_valid", 32'(audio_valid), 32'd1);
    chk("same_edge_data", 32'(audio_data), 32'h00222);
    chk("same_edge_no_ovr", 32'(overrun), 32'd0);

    // Tick and init_req during a step.
    pulse_tick(); cyc();
    sample_tick = 1'b1; cyc(); sample_tick = 1'b0;
    chk("wait_tick_ovr", 32'(overrun), 32'd1);
    init_req = 1'b1; cyc(); init_req = 1'b0;
    step_done(18'h00333);
    chk("pend_count_before", step_count, 32'd3);
    sweep();
    chk("pend_count_after", step_count, 32'd0);
    chk("pend_idle", 32'(busy), 32'd0);

    // One column never finishes: timeout.
    pulse_tick(); cyc();
    col_done = 2'b01; cyc(); col_done = '0;
    repeat (14) cyc();
    chk("to_busy_before", 32'(busy), 32'd1);
    chk("to_err_before", 32'(timeout_err), 32'd0);
    cyc();
    chk("to_idle", 32'(busy), 32'd0);
    chk("to_err", 32'(timeout_err), 32'd1);
    chk("to_valid_kept", 32'(audio_valid), 32'd1);
    chk("to_data_kept", 32'(audio_data), 32'h00333);
    chk("to_count_kept", step_count, 32'd0);

    repeat (2) cyc();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/drum_step_scheduler.md
Name: drum_step_scheduler

Overview:
- Sequences time steps of the drum-mesh solver: one step per audio sample strobe, across NCOLS column engines, each holding its column of nodes in M10K.
- Handles the initialization sweep (pluck shape load), a stable rho_eff update at step boundaries, and capture of the center-node sample.
- Delivers each captured sample to the audio path over a valid/ready handshake.
- Sits between the audio-rate tick generator / HPS config registers and the column engines.

Parameters:
- NCOLS, 1, number of column engines; width of col_done.
- RHO_DEFAULT, 18'h02000, reset value of rho_eff (1.17 signed fixed point, = 0.0625).
- TIMEOUT, 1023, max cycles in S_WAIT before the step is aborted.

Ports:
- clk_50  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- sample_tick  in  1  one-cycle audio-rate strobe requesting one time step.
- init_req  in  1  one-cycle request to re-run the initialization sweep (new strike).
- rho_in  in  18  new rho_eff value, 1.17 signed.
- rho_wr  in  1  load rho_in into shadow register.
- col_done  in  NCOLS  per-column one-cycle done pulse (init or step).
- center_val  in  18  center node u_next, valid in the cycle the last col_done arrives and the cycle after.
- col_init  out  1  one-cycle pulse starting the init sweep in all columns.
- col_start  out  1  one-cycle pulse starting one compute step in all columns.
- rho_eff  out  18  damping/tension coefficient to all columns, held constant during a step.
- audio_data  out  18  last captured sample, signed.
- audio_valid  out  1  audio_data holds an unconsumed sample.
- audio_ready  in  1  audio sink accepts sample when audio_valid && audio_ready.
- busy  out  1  high in every state except S_IDLE.
- step_count  out  32  completed steps since last init, wraps at 2^32.
- overrun  out  1  sticky: tick dropped or unconsumed sample overwritten; cleared only by reset.
- timeout_err  out  1  sticky: a step hit TIMEOUT; cleared only by reset.

Behaviour:
- Reset values (async, reset low):
  - state = S_INIT.
  - col_init, col_start, audio_valid, overrun, timeout_err = 0.
  - audio_data = 0, step_count = 0.
  - rho_eff and shadow = RHO_DEFAULT.
  - done_mask = 0.
- All outputs are registered.
- States:
  - S_INIT: col_init = 1 for exactly one cycle, done_mask cleared. Next state S_IWAIT.
  - S_IWAIT: OR col_done into done_mask. When the mask is all ones, including bits arriving this cycle, go to S_IDLE. Clear step_count and done_mask.
  - S_IDLE: if init_req or a pending init, go to S_INIT; init has priority over a simultaneous tick, and that tick is dropped with overrun set. Otherwise, on sample_tick, go to S_START.
  - S_START: col_start = 1 for one cycle, rho_eff <= shadow, done_mask cleared, timer = 0. Next state S_WAIT.
  - S_WAIT: OR col_done into done_mask; timer++.
    - When the mask is full: audio_data <= center_val, audio_valid <= 1, step_count++, go to S_IDLE.
    - If timer == TIMEOUT first: set timeout_err, go to S_IDLE without capture or count.
- Latency:
  - Tick sampled at edge k gives col_start high during cycle k+1..k+2 (asserted at edge k+1).
  - Final col_done sampled at edge m gives audio_valid high from edge m+1.
- col_done pulses in S_IDLE or S_START are ignored. A duplicate pulse from the same column has no effect.
- sample_tick in any state other than S_IDLE: dropped, overrun set.
- init_req in any state other than S_IDLE: latched as pending and serviced on the next entry to S_IDLE. Multiple requests collapse into one.
- rho_wr updates the shadow register any cycle; the new value reaches rho_eff only in S_START. Simultaneous rho_wr and S_START: rho_eff takes the old shadow, and the shadow takes rho_in.
- Audio handshake:
  - audio_valid && audio_ready at an edge clears audio_valid.
  - A capture while audio_valid is still 1 and not accepted that edge overwrites audio_data and sets overrun.
  - A capture and an acceptance on the same edge leave audio_valid = 1 with the new data, and no overrun.
- Reset asserted mid-step: immediate return to reset values; the next step must be preceded by the init sweep.

Test Plan:
- Reset, NCOLS = 2; col_done pulses at cycles 5 and 9 after col_init -> col_init high exactly 1 cycle; busy drops one cycle after the cycle-9 pulse; step_count = 0; rho_eff = 18'h02000.
- Idle, tick; both col_done pulse together with center_val = 18'h01B4C -> col_start is a single pulse one cycle after the tick; audio_data = 18'h01B4C and audio_valid = 1 one cycle after done; step_count = 1.
- rho_wr with 18'h04000 mid-step, then a second tick -> rho_eff stays 18'h02000 until that step's S_START, then becomes 18'h04000.
- Hold audio_ready = 0 across two steps -> second capture overwrites data and overrun = 1. Repeat with audio_ready = 1 on the capture edge -> no overrun.
- Tick during S_WAIT, and init_req during S_WAIT -> tick dropped with overrun set; after the step completes, S_INIT is entered without a new request and step_count resets to 0.
- One column never pulses col_done, TIMEOUT = 15 -> S_IDLE 16 cycles after col_start; timeout_err = 1; audio_valid unchanged; step_count unchanged.
